// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// The debug struct uses fixed 4-bit fields because N and MAX_BURST are both capped at 16.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   typedef struct packed {
      arb_state_t state;
      logic [3:0] rr_ptr;
      logic [3:0] beat_cnt;
   } arb_dbg_t;

   // Counter/index width. This is never below 1, so it is safe for N = 2 or MAX_BURST = 1.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotate-priority finder.
// It searches two concatenated copies of req, masked below ptr, so the wrap is implicit.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] masked;
   logic [IW:0]    pos;

   always_comb begin
      masked = {req, req} & ({(2*N){1'b1}} << ptr);
      any    = |req;
      pos    = '0;
      for (int i = 2*N-1; i >= 0; i--) begin
         if (masked[i]) pos = (IW+1)'(i);
      end
      // A hit in the upper copy is a wrapped index into the lower copy.
      if (pos >= (IW+1)'(N)) idx = IW'(pos - (IW+1)'(N));
      else                   idx = IW'(pos);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N valid/ready producers.
// Each grant lasts a bounded burst. Priority rotates past the granted lane on release.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N         = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4,
   localparam int IW       = clog2_min1(N),
   localparam int BW       = clog2_min1(MAX_BURST)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req_valid,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]  req_ready,
   input  logic          fifo_full,
   output logic          fifo_wen,
   output logic [DW-1:0] fifo_data,
   output logic          grant_valid,
   output logic [IW-1:0] grant_id,
   output arb_dbg_t      dbg
);

   // Handshake: a lane byte moves when req_valid[i] & req_ready[i] at a rising edge.
   // req_ready is asserted only for the granted lane, and only while the FIFO is not full.
   arb_state_t    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] gid_q, gid_d;
   logic [BW-1:0] beat_q, beat_d;

   logic          pick_any;
   logic [IW-1:0] pick_idx;
   logic          sel_valid;
   logic [DW-1:0] sel_data;
   logic          rel;

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARB_IDLE;
         rr_ptr_q <= '0;
         gid_q    <= '0;
         beat_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gid_q    <= gid_d;
         beat_q   <= beat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gid_d     = gid_q;
      beat_d    = beat_q;
      req_ready = '0;
      fifo_wen  = 1'b0;
      fifo_data = '0;
      sel_valid = 1'b0;
      sel_data  = '0;
      rel       = 1'b0;

      for (int i = 0; i < N; i++) begin
         if (gid_q == IW'(i)) begin
            sel_valid = req_valid[i];
            sel_data  = req_data[i*DW +: DW];
         end
      end

      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_BURST;
               gid_d   = pick_idx;
               beat_d  = '0;
            end
         end
         ARB_BURST: begin
            for (int i = 0; i < N; i++) begin
               req_ready[i] = (gid_q == IW'(i)) && !fifo_full;
            end
            fifo_wen  = sel_valid && !fifo_full;
            fifo_data = sel_data;
            // A full stall keeps the grant and leaves the beat count unchanged.
            if (!sel_valid) begin
               rel = 1'b1;
            end else if (fifo_wen) begin
               if (beat_q == BW'(MAX_BURST-1)) rel = 1'b1;
               else                            beat_d = beat_q + 1'b1;
            end
            if (rel) begin
               state_d  = ARB_IDLE;
               beat_d   = '0;
               rr_ptr_d = (gid_q == IW'(N-1)) ? '0 : gid_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign grant_valid  = (state_q == ARB_BURST);
   assign grant_id     = gid_q;
   assign dbg.state    = state_q;
   assign dbg.rr_ptr   = 4'(rr_ptr_q);
   assign dbg.beat_cnt = 4'(beat_q);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. Lane producers and a FIFO occupancy model drive the DUT.
// A monitor scores every FIFO write against expected queues.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N = 4;
   localparam int DW = 8;
   localparam int MAX_BURST = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data  = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_wen;
   logic [DW-1:0]   fifo_data;
   logic            grant_valid;
   logic [1:0]      grant_id;
   arb_dbg_t        dbg;

   fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wen(fifo_wen),
      .fifo_data(fifo_data), .grant_valid(grant_valid), .grant_id(grant_id), .dbg(dbg)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int fifo_cnt = 0;
   logic e2e = 1'b0;
   logic mode_order = 1'b1;
   logic full_drv = 1'b0;

   logic [DW-1:0] lane_q[N][$];
   logic [DW-1:0] lane_exp[N][$];
   logic [9:0]    exp_q[$];
   int            wcyc[$];

   // The FIFO model reports full at 15 entries, matching wptr+1 == rptr.
   assign fifo_full = e2e ? (fifo_cnt == 15) : full_drv;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   task automatic push_exp(input int id, input logic [7:0] d);
      exp_q.push_back({2'(id), d});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < N; i++) lane_q[i].delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      bit done;
      n = 0;
      done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (exp_q.size() == 0) && !grant_valid && (req_valid == '0);
         for (int i = 0; i < N; i++) begin
            if (lane_q[i].size() != 0 || lane_exp[i].size() != 0) done = 0;
         end
      end
      if (!done) chk({name, "_drain_timeout"}, 1, 0);
   endtask

   task automatic wait_first_write(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fifo_wen && n < 30);
      if (!fifo_wen) chk({name, "_first_write_timeout"}, 1, 0);
   endtask

   task automatic chk_deltas(input string name, input int d[$]);
      chk({name, "_write_count"}, wcyc.size(), d.size());
      if (wcyc.size() > 0) begin
         for (int i = 0; i < d.size() && i < wcyc.size(); i++) begin
            chk($sformatf("%s_delta%0d", name, i), wcyc[i] - wcyc[0], d[i]);
         end
      end
   endtask

   // producer lanes and FIFO reader
   logic [N-1:0] acc;
   logic wr, rd;
   initial begin
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         wr  = fifo_wen;
         rd  = e2e && (fifo_cnt > 0) && ($urandom_range(0, 1) == 1);
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
         end
         if (rd) rd_cnt++;
         fifo_cnt = fifo_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
         for (int i = 0; i < N; i++) begin
            if (lane_q[i].size() > 0 && !rst) begin
               req_valid[i] = 1'b1;
               req_data[i*DW +: DW] = lane_q[i][0];
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (fifo_wen) begin
         wcyc.push_back(cyc);
         chk("wen_while_full", fifo_full, 0);
         if (mode_order) begin
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else chk("write_id_data", {grant_id, fifo_data}, exp_q.pop_front());
         end else begin
            wr_cnt++;
            if (lane_exp[grant_id].size() == 0) chk("unexpected_lane_write", 1, 0);
            else chk("lane_order", fifo_data, lane_exp[grant_id].pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int d[$];
      int n;

      // reset state
      #12;
      chk("rst_wen", fifo_wen, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_fifo_data", fifo_data, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_state", dbg.state, ARB_IDLE);
      chk("rst_rr_ptr", dbg.rr_ptr, 0);
      chk("rst_beat_cnt", dbg.beat_cnt, 0);
      chk("rst_grant_id", grant_id, 0);

      // single lane, 6 bytes: bursts of 4 + 2 with one bubble
      wcyc.delete();
      for (int b = 0; b < 6; b++) begin
         push_exp(2, 8'hA1 + 8'(b));
         lane_q[2].push_back(8'hA1 + 8'(b));
      end
      wait_drain("single", 60);
      d = '{0, 1, 2, 3, 5, 6};
      chk_deltas("single", d);

      // all four lanes, 2 bytes each, grants 0..3
      do_reset();
      wcyc.delete();
      for (int i = 0; i < N; i++) begin
         for (int b = 0; b < 2; b++) begin
            push_exp(i, 8'(16*i + b));
            lane_q[i].push_back(8'(16*i + b));
         end
      end
      wait_drain("all4", 80);
      d = '{0, 1, 4, 5, 8, 9, 12, 13};
      chk_deltas("all4", d);

      // full stall on lane 1
      do_reset();
      for (int b = 0; b < 4; b++) begin
         push_exp(1, 8'h10 + 8'(b));
         lane_q[1].push_back(8'h10 + 8'(b));
      end
      wait_first_write("stall");
      @(posedge clk);
      #1 full_drv = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_wen", fifo_wen, 0);
         chk("stall_ready", req_ready, 0);
         chk("stall_grant_valid", grant_valid, 1);
         chk("stall_grant_id", grant_id, 1);
         chk("stall_beat_cnt", dbg.beat_cnt, 1);
         @(posedge clk);
         #1;
      end
      full_drv = 1'b0;
      @(negedge clk);
      chk("stall_resume_wen", fifo_wen, 1);
      wait_drain("stall", 40);

      // early drop on lane 3 while lane 0 waits, pointer wraps to 0
      do_reset();
      push_exp(2, 8'h20);
      lane_q[2].push_back(8'h20);
      wait_drain("drop_pre", 30);
      chk("drop_rr_ptr_before", dbg.rr_ptr, 3);
      wcyc.delete();
      push_exp(3, 8'h30);
      push_exp(0, 8'h40);
      push_exp(0, 8'h41);
      lane_q[3].push_back(8'h30);
      lane_q[0].push_back(8'h40);
      lane_q[0].push_back(8'h41);
      wait_drain("drop", 40);
      d = '{0, 3, 4};
      chk_deltas("drop", d);
      chk("drop_rr_ptr_after", dbg.rr_ptr, 1);

      // asynchronous reset in the middle of a lane 1 burst
      push_exp(1, 8'h50);
      for (int b = 0; b < 4; b++) lane_q[1].push_back(8'h50 + 8'(b));
      wait_first_write("midrst");
      @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < N; i++) lane_q[i].delete();
      exp_q.delete();
      #1;
      chk("midrst_wen", fifo_wen, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_grant_valid", grant_valid, 0);
      chk("midrst_fifo_data", fifo_data, 0);
      chk("midrst_grant_id", grant_id, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_rr_ptr", dbg.rr_ptr, 0);
      chk("midrst_state", dbg.state, ARB_IDLE);

      // end-to-end: 20 bytes per lane into a 15-entry FIFO drained at 50%
      do_reset();
      mode_order = 1'b0;
      fifo_cnt = 0;
      e2e = 1'b1;
      for (int i = 0; i < N; i++) begin
         for (int b = 0; b < 20; b++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            lane_q[i].push_back(v);
            lane_exp[i].push_back(v);
         end
      end
      wait_drain("e2e", 3000);
      n = 0;
      while (fifo_cnt != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("e2e_fifo_empty", fifo_cnt, 0);
      chk("e2e_writes", wr_cnt, 80);
      chk("e2e_reads", rd_cnt, 80);
      e2e = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one `sync_fifo` write port (8-bit data, 16 entries) among N producers. Each producer offers bytes on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `wen`/`data` from the granted lane. It back-pressures on `full` and rotates priority fairly after each burst.

## Interface
- `N`, 4: number of requesters, 2..16.
- `DW`, 8: data width; must match the FIFO data width.
- `MAX_BURST`, 4: maximum beats per grant, 1..16.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N  lane i has a byte on offer.
- `req_data`  in  N*DW  lane i data at bits [i*DW +: DW].
- `req_ready`  out  N  lane i byte accepted this cycle when valid & ready.
- `fifo_full`  in  1  FIFO `full` flag.
- `fifo_wen`  out  1  FIFO write enable.
- `fifo_data`  out  DW  FIFO write data.
- `grant_valid`  out  1  a burst is in progress.
- `grant_id`  out  $clog2(N)  index of the granted lane; valid only while `grant_valid` is high.

## Operation
- Two-state FSM: IDLE and BURST.
- **IDLE:**
  - `req_ready` is all zero and `fifo_wen` is 0.
  - If any `req_valid` bit is set, pick the first set bit scanning `rr_ptr`, `rr_ptr+1`, … with wrap at N-1.
  - Register the pick as `grant_id`, clear `beat_cnt`, and go to BURST.
  - If no bit is set, stay in IDLE.
- **BURST** (g = `grant_id`):
  - `req_ready[g] = !fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wen = req_valid[g] & !fifo_full`.
  - `fifo_data = req_data[g]`. This is a combinational mux; `fifo_data` is a don't-care when `fifo_wen` is low.
  - A transfer is `fifo_wen` = 1. Each transfer increments `beat_cnt`.
- **Release:** at the end of a BURST cycle, go to IDLE and set `rr_ptr <= (g == N-1) ? 0 : g+1` when either:
  - a transfer occurs with `beat_cnt == MAX_BURST-1`, or
  - `req_valid[g]` is 0 (the requester dropped valid).
- **Full stall:** `fifo_full` high with `req_valid[g]` high holds the grant and does not count a beat. There is no timeout.
- **Handshake rule:** a producer must hold `req_valid` and `req_data` stable until accepted. Dropping `req_valid` ends its burst.
- **Width rules:**
  - `beat_cnt` width is max(1, $clog2(MAX_BURST)).
  - `rr_ptr` and `grant_id` width is max(1, $clog2(N)).
  - All increments wrap explicitly at N-1 or MAX_BURST-1, never by natural overflow.

## Timing
- **Reset values** (take effect asynchronously on `rst`): state = IDLE, `rr_ptr` = 0, `grant_id` = 0, `beat_cnt` = 0, `grant_valid` = 0, `req_ready` = 0, `fifo_wen` = 0, `fifo_data` = 0.
- **Reset mid-burst:** the burst is abandoned, and no write occurs in the cycle `rst` is sampled high.
- **Arbitration latency:** 1 cycle. A `req_valid` that rises in cycle t gives `grant_valid` in t+1, and the first write can occur in t+1.
- **Bubble:** every release costs one IDLE cycle, so the peak rate is MAX_BURST/(MAX_BURST+1) writes per cycle.
- **Full flag:** `fifo_full` is sampled combinationally. It is register-derived inside the FIFO, so there is no loop.
- **FIFO capacity:** the FIFO holds at most 15 entries because `full` asserts at `wptr+1 == rptr`. The arbiter only obeys the flag.
- **Contention:** simultaneous valid on all lanes gives grants in the order `rr_ptr`, `rr_ptr+1`, … with no lane starved.
- **Write and full in the same cycle:** a write in a cycle where the FIFO read side frees a slot is governed only by the current `fifo_full`.

## Structure
- `fifo_arb_pkg`: FSM state enum (`ARB_IDLE`, `ARB_BURST`) and width helper functions.
- Sub-module `rr_pick`: combinational rotate-priority finder.
  - Inputs: `req`[N], `ptr`.
  - Outputs: `any`, `idx`.
  - Implemented by double-width masking.
- Top level: FSM, counters, and output muxes. Target is about 150–250 lines of RTL.

## Test plan
- **Reset mid-burst:** assert `rst` asynchronously at mid-cycle during a burst.
  - All outputs go to 0 immediately, with no further `fifo_wen`.
  - After release of reset, `rr_ptr` is 0.
- **Single lane:** lane 2 offers 0xA1..0xA6 continuously, FIFO empty, MAX_BURST = 4.
  - FIFO receives A1..A4, then one idle cycle, then A5, A6.
  - `grant_id` = 2 throughout.
- **All four lanes:** all lanes valid continuously, each offering 2 bytes.
  - Grants go 0, 1, 2, 3 in order.
  - FIFO order is L0b0, L0b1, L1b0, L1b1, …, with 4 bubble cycles.
- **Full stall:** lane 1 granted, `fifo_full` forced high for 5 cycles.
  - `fifo_wen` = 0 and `req_ready` = 0 during the stall.
  - Grant is held and `beat_cnt` is unchanged.
  - Writes resume on the cycle `full` drops.
- **Early drop:** lane 3 drops valid after 1 beat while lane 0 is waiting.
  - Release, then one IDLE cycle, then `grant_id` = 0 (wraps past 3).
- **End-to-end:** 20 random bytes per lane into a real `sync_fifo`, with a reader draining at 50%.
  - Every byte is read exactly once.
  - Each lane's bytes appear in that lane's order.
  - No write occurs while `full` is high.
